// File: rtl/noc2_pkt_store_fwd_pkg.sv
// Shared types and constants for the NoC2 store-and-forward buffer.
// FSM state enums, length-field defaults and count width helper.
package noc2_pkt_store_fwd_pkg;

  typedef enum logic [1:0] {
    IN_HDR  = 2'd0,
    IN_BODY = 2'd1,
    IN_DROP = 2'd2
  } in_state_e;

  typedef enum logic {
    OUT_HDR  = 1'b0,
    OUT_BODY = 1'b1
  } out_state_e;

  localparam int LEN_HI_DEF = 29;
  localparam int LEN_LO_DEF = 22;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with a registered head entry.
// Ports: clk/reset, wr_en/wr_data, rd_en/rd_data, full, empty, flit_count.
module noc_flit_fifo
  import noc2_pkt_store_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] flit_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;

  assign full       = (count_q == FULL_C);
  assign empty      = (count_q == '0);
  assign flit_count = count_q;
  assign rd_data    = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Head tracks the entry at the next read pointer; a write
    // landing on that slot this cycle must be forwarded.
    head_d = head_q;
    if (count_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/noc2_pkt_store_fwd.sv
// Store-and-forward packet buffer for the NoC2 request path.
// Ports: in_* val/rdy sink, out_* val/rdy source, counts, oversize_err.
module noc2_pkt_store_fwd
  import noc2_pkt_store_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int LEN_HI     = LEN_HI_DEF,
  parameter int LEN_LO     = LEN_LO_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [cnt_w(DEPTH)-1:0] flit_count,
  output logic [cnt_w(DEPTH)-1:0] pkt_count,
  output logic                    oversize_err
);

  localparam int LW = LEN_HI - LEN_LO + 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH - 1);
  localparam logic [LW-1:0] ONE     = LW'(1);

  in_state_e     in_state_q, in_state_d;
  out_state_e    out_state_q, out_state_d;
  logic [LW-1:0] in_rem_q, in_rem_d;
  logic [LW-1:0] out_rem_q, out_rem_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          err_q, err_d;

  logic          fifo_full, fifo_empty;
  logic          wr_en, rd_en;
  logic          in_fire, out_fire;
  logic          pkt_inc, pkt_dec;
  logic [LW-1:0] in_len, out_len;

  assign in_len  = in_data[LEN_HI:LEN_LO];
  assign out_len = out_data[LEN_HI:LEN_LO];

  // Dropping never touches storage, so it ignores fullness.
  assign in_ready = !reset &&
                    ((in_state_q == IN_DROP) || !fifo_full);
  assign in_fire  = in_valid && in_ready;

  // Body flits are only read for a packet already counted complete.
  assign out_valid = (out_state_q == OUT_BODY) ||
                     (pkt_count_q != '0);
  assign out_fire  = out_valid && out_ready;

  assign pkt_count    = pkt_count_q;
  assign oversize_err = err_q;

  noc_flit_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (in_data),
    .rd_en     (rd_en),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .flit_count(flit_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q  <= IN_HDR;
      out_state_q <= OUT_HDR;
      in_rem_q    <= '0;
      out_rem_q   <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_rem_q    <= in_rem_d;
      out_rem_q   <= out_rem_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    in_rem_d   = in_rem_q;
    err_d      = err_q;
    unique case (in_state_q)
      IN_HDR: begin
        if (in_fire) begin
          if (in_len > MAX_LEN) begin
            err_d      = 1'b1;
            in_rem_d   = in_len;
            in_state_d = IN_DROP;
          end else if (in_len != '0) begin
            in_rem_d   = in_len;
            in_state_d = IN_BODY;
          end
        end
      end
      IN_BODY, IN_DROP: begin
        if (in_fire) begin
          in_rem_d = in_rem_q - ONE;
          if (in_rem_q == ONE) begin
            in_state_d = IN_HDR;
          end
        end
      end
      default: in_state_d = IN_HDR;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    pkt_inc = 1'b0;
    unique case (in_state_q)
      IN_HDR: begin
        wr_en   = in_fire && (in_len <= MAX_LEN);
        pkt_inc = in_fire && (in_len == '0);
      end
      IN_BODY: begin
        wr_en   = in_fire;
        pkt_inc = in_fire && (in_rem_q == ONE);
      end
      default: begin
        wr_en   = 1'b0;
        pkt_inc = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    out_rem_d   = out_rem_q;
    unique case (out_state_q)
      OUT_HDR: begin
        if (out_fire && (out_len != '0)) begin
          out_rem_d   = out_len;
          out_state_d = OUT_BODY;
        end
      end
      OUT_BODY: begin
        if (out_fire) begin
          out_rem_d = out_rem_q - ONE;
          if (out_rem_q == ONE) begin
            out_state_d = OUT_HDR;
          end
        end
      end
      default: out_state_d = OUT_HDR;
    endcase
  end

  always_comb begin
    rd_en   = out_fire && !fifo_empty;
    pkt_dec = 1'b0;
    unique case (out_state_q)
      OUT_HDR:  pkt_dec = out_fire && (out_len == '0);
      OUT_BODY: pkt_dec = out_fire && (out_rem_q == ONE);
      default:  pkt_dec = 1'b0;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    unique case (1'b1)
      (pkt_inc && !pkt_dec): pkt_count_d = pkt_count_q + CW'(1);
      (pkt_dec && !pkt_inc): pkt_count_d = pkt_count_q - CW'(1);
      default:               pkt_count_d = pkt_count_q;
    endcase
  end

endmodule

// File: tb/tb_noc2_pkt_store_fwd.sv
// Self-checking bench for noc2_pkt_store_fwd.
// Directed scenarios plus randomized traffic against a queue model.
module tb_noc2_pkt_store_fwd;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] flit_count;
  logic [CW-1:0] pkt_count;
  logic          oversize_err;

  always #5 clk = ~clk;

  noc2_pkt_store_fwd #(
    .DATA_WIDTH(64),
    .DEPTH     (DEPTH),
    .LEN_HI    (29),
    .LEN_LO    (22)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flit_count  (flit_count),
    .pkt_count   (pkt_count),
    .oversize_err(oversize_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: flits of complete packets in order, the
  // partial packet being assembled, and per-packet flits left.
  logic [63:0] exp_q[$];
  logic [63:0] part_q[$];
  int          pkt_left[$];
  int          in_rem   = 0;
  bit          dropping = 0;
  bit          m_err    = 0;
  bit          m_fire   = 0;

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] mk_hdr(input int len);
    logic [63:0] d;
    d = rnd64();
    d[29:22] = len[7:0];
    return d;
  endfunction

  function automatic bit m_in_ready();
    return !reset &&
           (dropping || (exp_q.size() + part_q.size() != DEPTH));
  endfunction

  function automatic int m_flits();
    return exp_q.size() + part_q.size();
  endfunction

  task automatic model_update();
    bit ifire, ofire;
    int len;
    if (reset) begin
      exp_q.delete(); part_q.delete(); pkt_left.delete();
      in_rem = 0; dropping = 0; m_err = 0; m_fire = 0;
      return;
    end
    ifire  = in_valid && m_in_ready();
    ofire  = out_ready && (exp_q.size() != 0);
    m_fire = ifire;
    if (ofire) begin
      void'(exp_q.pop_front());
      pkt_left[0] = pkt_left[0] - 1;
      if (pkt_left[0] == 0) void'(pkt_left.pop_front());
    end
    if (ifire) begin
      if (in_rem == 0) begin
        len = int'(in_data[29:22]);
        if (len > DEPTH - 1) begin
          m_err = 1; dropping = 1; in_rem = len;
        end else if (len == 0) begin
          exp_q.push_back(in_data);
          pkt_left.push_back(1);
        end else begin
          part_q.push_back(in_data);
          in_rem = len;
        end
      end else begin
        in_rem--;
        if (!dropping) part_q.push_back(in_data);
        if (in_rem == 0) begin
          if (!dropping) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            pkt_left.push_back(part_q.size());
            part_q.delete();
          end
          dropping = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] d,
                       input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 64'h0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready_hi: got %b want 0", in_ready);
    end
    advance();
    reset = 1'b0;
    drive(0, 64'h0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_out: got v=%b d=%h want 0/0",
               out_valid, out_data);
    end
    checks++;
    if (flit_count !== 5'd0 || pkt_count !== 5'd0 ||
        oversize_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_counts: got f=%0d p=%0d e=%b want 0",
               flit_count, pkt_count, oversize_err);
    end
    advance();
  endtask

  task automatic test_single();
    logic [63:0] f[3];
    f[0] = mk_hdr(2); f[1] = rnd64(); f[2] = rnd64();
    for (int c = 0; c < 7; c++) begin
      drive(c < 3, (c < 3) ? f[c % 3] : 64'h0, 1);
      if (c < 3) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL single_fill c=%0d: got v=%b r=%b want 0/1",
                   c, out_valid, in_ready);
        end
      end else if (c < 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== f[c-3] ||
            pkt_count !== 5'd1) begin
          errors++;
          $display("FAIL single_out c=%0d: got v=%b d=%h p=%0d want 1/%h/1",
                   c, out_valid, out_data, pkt_count, f[c-3]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 5'd0 ||
            flit_count !== 5'd0) begin
          errors++;
          $display("FAIL single_end: got v=%b p=%0d f=%0d want 0/0/0",
                   out_valid, pkt_count, flit_count);
        end
      end
      advance();
    end
  endtask

  task automatic test_hdr_only();
    logic [63:0] h;
    h = mk_hdr(0);
    drive(1, h, 0);
    advance();
    drive(0, 64'h0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== h ||
        pkt_count !== 5'd1 || flit_count !== 5'd1) begin
      errors++;
      $display("FAIL hdr_only_out: got v=%b d=%h p=%0d f=%0d want 1/%h/1/1",
               out_valid, out_data, pkt_count, flit_count, h);
    end
    advance();
    drive(0, 64'h0, 0);
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== 5'd0 ||
        flit_count !== 5'd0) begin
      errors++;
      $display("FAIL hdr_only_end: got v=%b p=%0d f=%0d want 0/0/0",
               out_valid, pkt_count, flit_count);
    end
    advance();
  endtask

  task automatic test_full();
    logic [63:0] f[16];
    for (int i = 0; i < 16; i++)
      f[i] = (i % 8 == 0) ? mk_hdr(7) : rnd64();
    for (int i = 0; i < 16; i++) begin
      drive(1, f[i], 0);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill i=%0d: got in_ready=%b want 1",
                 i, in_ready);
      end
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, mk_hdr(0), 0);
      checks++;
      if (in_ready !== 1'b0 || flit_count !== 5'd16 ||
          pkt_count !== 5'd2 || out_data !== f[0]) begin
        errors++;
        $display("FAIL full_state: got r=%b f=%0d p=%0d d=%h want 0/16/2/%h",
                 in_ready, flit_count, pkt_count, out_data, f[0]);
      end
      advance();
    end
    for (int i = 0; i < 16; i++) begin
      drive(i == 0, mk_hdr(0), 1);
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_no_bypass: got in_ready=%b want 0",
                   in_ready);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== f[i]) begin
        errors++;
        $display("FAIL full_drain i=%0d: got v=%b d=%h want 1/%h",
                 i, out_valid, out_data, f[i]);
      end
      advance();
    end
    drive(0, 64'h0, 0);
    checks++;
    if (in_ready !== 1'b1 || flit_count !== 5'd0 ||
        pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL full_after: got r=%b f=%0d p=%0d want 1/0/0",
               in_ready, flit_count, pkt_count);
    end
    advance();
  endtask

  task automatic test_oversize();
    logic [63:0] p[2];
    drive(1, mk_hdr(20), 0);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(1, rnd64(), 0);
      checks++;
      if (in_ready !== 1'b1 || flit_count !== 5'd0 ||
          oversize_err !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop i=%0d: got r=%b f=%0d e=%b v=%b want 1/0/1/0",
                 i, in_ready, flit_count, oversize_err, out_valid);
      end
      advance();
    end
    p[0] = mk_hdr(1); p[1] = rnd64();
    for (int i = 0; i < 2; i++) begin
      drive(1, p[i], 0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 64'h0, 1);
      checks++;
      if (i < 2 && (out_valid !== 1'b1 || out_data !== p[i])) begin
        errors++;
        $display("FAIL after_drop i=%0d: got v=%b d=%h want 1/%h",
                 i, out_valid, out_data, p[i]);
      end else if (i == 2 && (out_valid !== 1'b0 ||
                              oversize_err !== 1'b1)) begin
        errors++;
        $display("FAIL after_drop_end: got v=%b e=%b want 0/1",
                 out_valid, oversize_err);
      end
      advance();
    end
  endtask

  task automatic test_partial();
    logic [63:0] f[4];
    f[0] = mk_hdr(3);
    for (int i = 1; i < 4; i++) f[i] = rnd64();
    for (int c = 0; c < 12; c++) begin
      if (c < 2)      drive(1, f[c], 1);
      else if (c < 6) drive(0, 64'h0, 1);
      else if (c < 8) drive(1, f[c-4], 1);
      else            drive(0, 64'h0, 1);
      if (c >= 2 && c < 6) begin
        checks++;
        if (out_valid !== 1'b0 || flit_count !== 5'd2) begin
          errors++;
          $display("FAIL partial_stall c=%0d: got v=%b f=%0d want 0/2",
                   c, out_valid, flit_count);
        end
      end else if (c < 8) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL partial_early c=%0d: got v=%b want 0",
                   c, out_valid);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== f[c-8]) begin
          errors++;
          $display("FAIL partial_out c=%0d: got v=%b d=%h want 1/%h",
                   c, out_valid, out_data, f[c-8]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] f[5];
    logic [63:0] h;
    f[0] = mk_hdr(1); f[1] = rnd64();
    f[2] = mk_hdr(5); f[3] = rnd64(); f[4] = rnd64();
    drive(1, mk_hdr(16), 0);
    advance();
    for (int i = 0; i < 16; i++) begin
      drive(1, rnd64(), 0);
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, f[i], 0);
      advance();
    end
    drive(0, 64'h0, 0);
    checks++;
    if (flit_count !== 5'd5 || pkt_count !== 5'd1 ||
        oversize_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got f=%0d p=%0d e=%b want 5/1/1",
               flit_count, pkt_count, oversize_err);
    end
    advance();
    reset = 1'b1;
    drive(1, mk_hdr(0), 1);
    advance();
    reset = 1'b0;
    drive(0, 64'h0, 0);
    checks++;
    if (flit_count !== 5'd0 || pkt_count !== 5'd0 ||
        out_valid !== 1'b0 || oversize_err !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_post: got f=%0d p=%0d v=%b e=%b r=%b want 0/0/0/0/1",
               flit_count, pkt_count, out_valid, oversize_err, in_ready);
    end
    advance();
    h = mk_hdr(0);
    drive(1, h, 0);
    advance();
    drive(0, 64'h0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== h || pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL mid_hdr: got v=%b d=%h p=%0d want 1/%h/1",
               out_valid, out_data, pkt_count, h);
    end
    advance();
    drive(0, 64'h0, 0);
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL mid_hdr_end: got v=%b p=%0d want 0/0",
               out_valid, pkt_count);
    end
    advance();
  endtask

  task automatic test_random();
    logic [63:0] tx_q[$];
    int len;
    int cyc;
    bit v, r;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(16, 22);
      else                           len = $urandom_range(0, 15);
      tx_q.push_back(mk_hdr(len));
      for (int b = 0; b < len; b++) tx_q.push_back(rnd64());
    end
    cyc = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < 6000) begin
      v = (tx_q.size() != 0) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, v ? tx_q[0] : 64'h0, r);
      checks++;
      if (in_ready !== m_in_ready()) begin
        errors++;
        $display("FAIL rnd_in_ready cyc=%0d: got %b want %b",
                 cyc, in_ready, m_in_ready());
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_out_valid cyc=%0d: got %b want %b",
                 cyc, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_out_data cyc=%0d: got %h want %h",
                   cyc, out_data, exp_q[0]);
        end
      end
      checks++;
      if (flit_count !== CW'(m_flits()) ||
          pkt_count !== CW'(pkt_left.size()) ||
          oversize_err !== m_err) begin
        errors++;
        $display("FAIL rnd_counts cyc=%0d: got f=%0d p=%0d e=%b want %0d/%0d/%b",
                 cyc, flit_count, pkt_count, oversize_err,
                 m_flits(), pkt_left.size(), m_err);
      end
      advance();
      if (m_fire) void'(tx_q.pop_front());
      cyc++;
    end
    checks++;
    if (tx_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d unsent %0d unread want 0/0",
               tx_q.size(), exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_hdr_only();
    test_full();
    test_oversize();
    test_partial();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
